// File: rtl/bcd_display_controller.sv
// bcd_display_controller
// Front-end for the 4-digit multiplexed 7-segment driver. It accepts a binary
// value over valid/ready, converts it to BCD with a serial shift-add-3 engine,
// and presents d3..d0 with optional leading-zero blanking. Values above 9999
// show a blinking saturated 9-9-9-9. Digit code 4'hF means blank.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for in_valid; the overflow blink timer runs here
// S_SHIFT | one double-dabble iteration per cycle, WIDTH iterations
// S_LATCH | commit the result (blanked) and the overflow flag
//
// The d outputs and overflow sit one register stage behind the committed
// result, so they change one cycle after S_LATCH and never show a partial
// conversion.
module bcd_display_controller #(
    parameter int WIDTH       = 14,
    parameter int LZB         = 1,
    parameter int BLINK_TICKS = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [15:0]       bcd;
    logic [3:0]        iter;
    logic              ovf_stage;
    logic              ovf_q;
    logic [15:0]       disp;
    logic [BW-1:0]     blink_cnt;
    logic              phase_on;
    logic              too_big;

    // Every nibble of 5 or more gets +3 ahead of the shift.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Leading-zero blanking; the units digit always stays visible.
    function automatic logic [15:0] blank_lz(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        if (LZB != 0) begin
            if (b[15:12] == 4'd0) r[15:12] = 4'hF;
            if (b[15:8] == 8'd0)  r[11:8]  = 4'hF;
            if (b[15:4] == 12'd0) r[7:4]   = 4'hF;
        end
        return r;
    endfunction

    // Zero-extended compare so narrow WIDTH settings can never flag overflow.
    assign too_big = (32'(in_value) > 32'd9999);

    // Conversion FSM, blink timer and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            shreg     <= '0;
            bcd       <= '0;
            iter      <= '0;
            ovf_stage <= 1'b0;
            ovf_q     <= 1'b0;
            disp      <= 16'hFFFF;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            d3        <= 4'hF;
            d2        <= 4'hF;
            d1        <= 4'hF;
            d0        <= 4'hF;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ovf_q) begin
                        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                            blink_cnt <= '0;
                            phase_on  <= ~phase_on;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (too_big) begin
                            bcd       <= 16'h9999;
                            ovf_stage <= 1'b1;
                            state     <= S_LATCH;
                        end else begin
                            shreg     <= in_value;
                            bcd       <= '0;
                            iter      <= '0;
                            ovf_stage <= 1'b0;
                            state     <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    {bcd, shreg} <= {add3(bcd), shreg} << 1;
                    iter         <= iter + 1'b1;
                    if (iter == 4'(WIDTH - 1)) state <= S_LATCH;
                end
                S_LATCH: begin
                    disp      <= ovf_stage ? bcd : blank_lz(bcd);
                    ovf_q     <= ovf_stage;
                    blink_cnt <= '0;
                    phase_on  <= 1'b1;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase

            if (ovf_q && !phase_on) {d3, d2, d1, d0} <= 16'hFFFF;
            else                    {d3, d2, d1, d0} <= disp;
            overflow <= ovf_q;
        end
    end

endmodule

// File: tb/tb_bcd_display_controller.sv
// Bench for bcd_display_controller: two instances (blanking on / off) share
// stimulus; expected displays are queued at accept and popped when due.
module tb_bcd_display_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [13:0] in_value;
    logic        in_ready, busy, overflow;
    logic [3:0]  d3, d2, d1, d0;
    logic        in_ready2, busy2, overflow2;
    logic [3:0]  e3, e2, e1, e0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_display_controller #(.WIDTH(14), .LZB(1), .BLINK_TICKS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .busy(busy), .overflow(overflow)
    );

    bcd_display_controller #(.WIDTH(14), .LZB(0), .BLINK_TICKS(4)) dut_nl (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_value(in_value), .d3(e3), .d2(e2), .d1(e1), .d0(e0),
        .busy(busy2), .overflow(overflow2)
    );

    typedef struct {
        int          v;
        logic [15:0] e;
        logic [15:0] enl;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [15:0] dnl;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input int v);
        int n;
        n = 0;
        in_value = 14'(v);
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] dnl, input logic ovf);
        exp_t e;
        e.d = d; e.dnl = dnl; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_digits"}, 32'({d3, d2, d1, d0}), 32'(e.d));
            chk({nm, "_digits_nolzb"}, 32'({e3, e2, e1, e0}), 32'(e.dnl));
            chk({nm, "_overflow"}, 32'(overflow), 32'(e.ovf));
            chk({nm, "_overflow_nolzb"}, 32'(overflow2), 32'(e.ovf));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev, prev_nl;
        int acc_cyc[3];
        int nacc, last_acc;
        int dq[$];
        int vals[3];

        tbl[0] = '{1234, 16'h1234, 16'h1234};
        tbl[1] = '{0,    16'hFFF0, 16'h0000};
        tbl[2] = '{7,    16'hFFF7, 16'h0007};
        tbl[3] = '{405,  16'hF405, 16'h0405};
        tbl[4] = '{9999, 16'h9999, 16'h9999};
        tbl[5] = '{8000, 16'h8000, 16'h8000};
        tbl[6] = '{100,  16'hF100, 16'h0100};

        reset = 1'b1; in_valid = 1'b0; in_value = '0;
        cycles(3);
        chk("rst_digits", 32'({d3, d2, d1, d0}), 32'hFFFF);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        cycles(1);

        // Reset asserted in the middle of a conversion.
        accept(1234);
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("midrst_digits", 32'({d3, d2, d1, d0}), 32'hFFFF);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        prev = 16'hFFFF; prev_nl = 16'hFFFF;

        for (int i = 0; i < 7; i++) begin
            accept(tbl[i].v);
            push(tbl[i].e, tbl[i].enl, 1'b0);
            chk($sformatf("v%0d_ready_low", tbl[i].v), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d_busy", tbl[i].v), 32'(busy2), 32'd1);
            cycles(15);
            chk($sformatf("v%0d_hold", tbl[i].v), 32'({d3, d2, d1, d0}), 32'(prev));
            chk($sformatf("v%0d_hold_nolzb", tbl[i].v), 32'({e3, e2, e1, e0}), 32'(prev_nl));
            chk($sformatf("v%0d_ready_back", tbl[i].v), 32'(in_ready), 32'd1);
            cycles(1);
            check_sb($sformatf("v%0d", tbl[i].v));
            chk($sformatf("v%0d_busy_done", tbl[i].v), 32'(busy), 32'd0);
            prev = tbl[i].e; prev_nl = tbl[i].enl;
        end

        // Overflow and blink.
        accept(12000);
        push(16'h9999, 16'h9999, 1'b1);
        cycles(2);
        check_sb("ovf12000");
        cycles(3);
        chk("blink_on_p5", 32'({d3, d2, d1, d0}), 32'h9999);
        cycles(1);
        chk("blink_off_p6", 32'({d3, d2, d1, d0}), 32'hFFFF);
        chk("blink_ovf_p6", 32'(overflow), 32'd1);
        cycles(4);
        chk("blink_on_p10", 32'({d3, d2, d1, d0}), 32'h9999);
        accept(56);
        push(16'hFF56, 16'h0056, 1'b0);
        cycles(16);
        check_sb("clear56");
        cycles(9);
        chk("steady56", 32'({d3, d2, d1, d0}), 32'hFF56);
        chk("steady56_ovf", 32'(overflow), 32'd0);

        // Boundaries around 9999.
        accept(10000);
        push(16'h9999, 16'h9999, 1'b1);
        cycles(2);
        check_sb("ovf10000");
        accept(16383);
        push(16'h9999, 16'h9999, 1'b1);
        cycles(2);
        check_sb("ovf16383");
        cycles(4);
        chk("blink16383_off", 32'({d3, d2, d1, d0}), 32'hFFFF);
        accept(9999);
        push(16'h9999, 16'h9999, 1'b0);
        cycles(16);
        check_sb("max9999");

        // Back-to-back with in_valid held high; in_value churns while busy.
        vals[0] = 10; vals[1] = 20; vals[2] = 30;
        nacc = 0; last_acc = -100;
        in_value = 14'(vals[0]);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                check_sb($sformatf("b2b_c%0d", cyc));
            end
            if (in_valid && in_ready) begin
                if (nacc < 3) acc_cyc[nacc] = cyc;
                case (nacc)
                    0: push(16'hFF10, 16'h0010, 1'b0);
                    1: push(16'hFF20, 16'h0020, 1'b0);
                    default: push(16'hFF30, 16'h0030, 1'b0);
                endcase
                dq.push_back(cyc + 17);
                nacc++;
                last_acc = cyc;
            end else if (cyc == last_acc + 1) begin
                in_value = 14'(777 + cyc);
                if (nacc >= 3) in_valid = 1'b0;
            end else if (cyc == last_acc + 5 && nacc < 3) begin
                in_value = 14'(vals[nacc]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_pending", 32'(dq.size()), 32'd0);
        if (nacc >= 3) begin
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd16);
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd16);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
